// File: rtl/chaos_arith_pkg.sv
// rtl/chaos_arith_pkg.sv - shared constants and types for the chaos-map fixed-point arithmetic units
package chaos_arith_pkg;

    localparam int WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract the divisor
module div_step #(
    parameter int WIDTH = chaos_arith_pkg::WIDTH
) (
    input  logic [WIDTH:0]   prem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             qbit
);

    logic [WIDTH+1:0] p;
    logic [WIDTH+1:0] diff;

    // One extra bit above the shifted remainder makes the subtract's MSB a clean borrow flag.
    always_comb begin
        p         = {prem, in_bit};
        diff      = p - {2'b00, divisor};
        qbit      = ~diff[WIDTH+1];
        prem_next = qbit ? diff[WIDTH:0] : p[WIDTH:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider, 2W/W -> 2W quotient, W remainder
module seq_restoring_divider #(
    parameter int WIDTH = chaos_arith_pkg::WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 calc_start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 done,
    output logic                 div_zero
);

    import chaos_arith_pkg::*;

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0] ALL_STEPS = CW'(2 * WIDTH);

    div_state_t           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [2*WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH:0]       prem_q, prem_d;
    logic [2*WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH:0]       step_prem;
    logic                 step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem_q),
        .in_bit    (shreg_q[2*WIDTH-1]),
        .divisor   (divisor_q),
        .prem_next (step_prem),
        .qbit      (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        shreg_d     = shreg_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        div_zero_d  = div_zero_q;

        if (!calc_start) begin
            state_d     = IDLE;
            count_d     = '0;
            quotient_d  = '0;
            remainder_d = '0;
            done_d      = 1'b0;
            div_zero_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    divisor_d = divisor;
                    shreg_d   = dividend;
                    prem_d    = '0;
                    count_d   = '0;
                    state_d   = (divisor == '0) ? FIN : RUN;
                end
                RUN: begin
                    prem_d  = step_prem;
                    shreg_d = {shreg_q[2*WIDTH-2:0], step_qbit};
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_d = FIN;
                    end
                end
                FIN: begin
                    // A zero divisor arrives with count=0 and spends one edge arming,
                    // so its result lands two edges after the load edge.
                    if (count_q != ALL_STEPS) begin
                        count_d = ALL_STEPS;
                    end else if (!done_q) begin
                        done_d = 1'b1;
                        if (divisor_q == '0) begin
                            quotient_d  = '1;
                            remainder_d = shreg_q[WIDTH-1:0];
                            div_zero_d  = 1'b1;
                        end else begin
                            quotient_d  = shreg_q;
                            remainder_d = prem_q[WIDTH-1:0];
                            div_zero_d  = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            count_q     <= '0;
            divisor_q   <= '0;
            shreg_q     <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            divisor_q   <= divisor_d;
            shreg_q     <= shreg_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and randomized checks for seq_restoring_divider
module tb_seq_restoring_divider;

    logic        CLK;
    logic        RST;
    logic        calc_start;
    logic [35:0] dividend;
    logic [17:0] divisor;
    logic [35:0] quotient;
    logic [17:0] remainder;
    logic        done;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    seq_restoring_divider #(.WIDTH(18)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .calc_start (calc_start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives the operands and raises calc_start; returns just after the load edge E0.
    task automatic start_op(input logic [35:0] a, input logic [17:0] b);
        dividend   = a;
        divisor    = b;
        calc_start = 1'b1;
        tick();
    endtask

    task automatic stop_op();
        calc_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1; calc_start = 1'b0; dividend = '0; divisor = '0;
        ticks(2);
        checks++; if (quotient !== 36'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 18'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b dz=%b exp=0,0", done, div_zero); end
        // Reset wins over a live request: several edges with both high must not produce a result.
        calc_start = 1'b1; dividend = 36'd100; divisor = 18'd7;
        ticks(40);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_holds_idle got done=%b exp=0", done); end
        calc_start = 1'b0;
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start_op(36'd100, 18'd7);
        ticks(36);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_not_early got done=%b at E36 exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_e37 got=%b exp=1", done); end
        checks++; if (quotient !== 36'd14 || remainder !== 18'd2 || div_zero !== 1'b0) begin
            errors++; $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b exp q=14 r=2 dz=0", quotient, remainder, div_zero);
        end
        // Holding the request with new operands must neither recompute nor drop done.
        dividend = 36'd200; divisor = 18'd3;
        ticks(5);
        checks++; if (done !== 1'b1 || quotient !== 36'd14 || remainder !== 18'd2) begin
            errors++; $display("FAIL basic_hold got done=%b q=%0d r=%0d exp 1 14 2", done, quotient, remainder);
        end
        stop_op();
    endtask

    task automatic test_extremes();
        start_op(36'hF_FFFF_FFFF, 18'h3FFFF);
        ticks(37);
        checks++; if (done !== 1'b1 || quotient !== 36'h4_0001 || remainder !== 18'd0) begin
            errors++; $display("FAIL max_over_max got done=%b q=%h r=%h exp 1 40001 0", done, quotient, remainder);
        end
        stop_op();
        checks++; if (done !== 1'b0 || quotient !== 36'd0 || remainder !== 18'd0) begin
            errors++; $display("FAIL clear_from_fin got done=%b q=%h r=%h exp 0 0 0", done, quotient, remainder);
        end
        start_op(36'h9_8765_4321, 18'd1);
        ticks(37);
        checks++; if (done !== 1'b1 || quotient !== 36'h9_8765_4321 || remainder !== 18'd0) begin
            errors++; $display("FAIL div_by_one got done=%b q=%h r=%h exp 1 987654321 0", done, quotient, remainder);
        end
        stop_op();
        start_op(36'd5, 18'd9);
        ticks(37);
        checks++; if (quotient !== 36'd0 || remainder !== 18'd5) begin
            errors++; $display("FAIL small_over_big got q=%0d r=%0d exp 0 5", quotient, remainder);
        end
        stop_op();
    endtask

    task automatic test_div_zero();
        start_op(36'd12345, 18'd0);
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_not_e1 got done=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1 || div_zero !== 1'b1) begin
            errors++; $display("FAIL dz_flags_e2 got done=%b dz=%b exp 1 1", done, div_zero);
        end
        checks++; if (quotient !== 36'hF_FFFF_FFFF || remainder !== 18'd12345) begin
            errors++; $display("FAIL dz_values got q=%h r=%0d exp FFFFFFFFF 12345", quotient, remainder);
        end
        stop_op();
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
    endtask

    task automatic test_abort();
        start_op(36'd1000, 18'd3);
        ticks(10);
        stop_op();
        checks++; if (done !== 1'b0 || quotient !== 36'd0 || remainder !== 18'd0) begin
            errors++; $display("FAIL abort_clear got done=%b q=%h r=%h exp 0 0 0", done, quotient, remainder);
        end
        start_op(36'd50, 18'd5);
        ticks(36);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_restart_early got done=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1 || quotient !== 36'd10 || remainder !== 18'd0) begin
            errors++; $display("FAIL abort_restart got done=%b q=%0d r=%0d exp 1 10 0", done, quotient, remainder);
        end
        stop_op();
    endtask

    task automatic test_reset_midrun();
        start_op(36'd200, 18'd9);
        ticks(14);
        RST = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || quotient !== 36'd0 || remainder !== 18'd0) begin
            errors++; $display("FAIL rst_midrun got done=%b q=%h r=%h exp 0 0 0", done, quotient, remainder);
        end
        tick();
        RST = 1'b0;
        tick();
        ticks(36);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_reload_early got done=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1 || quotient !== 36'd22 || remainder !== 18'd2) begin
            errors++; $display("FAIL rst_reload got done=%b q=%0d r=%0d exp 1 22 2", done, quotient, remainder);
        end
        RST = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || quotient !== 36'd0 || remainder !== 18'd0) begin
            errors++; $display("FAIL rst_in_fin got done=%b q=%h r=%h exp 0 0 0", done, quotient, remainder);
        end
        RST = 1'b0;
        stop_op();
    endtask

    task automatic test_operand_change();
        start_op(36'd1000, 18'd7);
        dividend = 36'd77777;
        divisor  = 18'd0;
        ticks(37);
        checks++; if (done !== 1'b1 || quotient !== 36'd142 || remainder !== 18'd6 || div_zero !== 1'b0) begin
            errors++; $display("FAIL operand_change got done=%b q=%0d r=%0d dz=%b exp 1 142 6 0", done, quotient, remainder, div_zero);
        end
        stop_op();
    endtask

    task automatic test_random();
        logic [31:0] lo;
        logic [3:0]  hi;
        logic [35:0] a;
        logic [17:0] b;
        logic [53:0] recon;
        int          bad = 0;
        for (int i = 0; i < 1000; i++) begin
            lo = $urandom;
            hi = 4'($urandom);
            a  = {hi, lo};
            b  = (i % 4 == 0) ? 18'($urandom_range(15, 1)) : 18'($urandom_range(262143, 1));
            start_op(a, b);
            dividend = ~a;
            divisor  = b ^ 18'h2AAAA;
            ticks(37);
            recon = {18'd0, quotient} * {36'd0, b} + {36'd0, remainder};
            checks++;
            if (done !== 1'b1 || recon !== {18'd0, a} || remainder >= b || div_zero !== 1'b0) begin
                errors++;
                if (bad < 10) $display("FAIL random_%0d a=%h b=%h got q=%h r=%h done=%b dz=%b", i, a, b, quotient, remainder, done, div_zero);
                bad++;
            end
            stop_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_abort();
        test_reset_midrun();
        test_operand_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
